isa_secuenciador: RTL

- Instruction sequencer for the ISA datapath (20-bit `Instruccion` in, 32-bit `Sailida` out).
- Buffers a short program in an internal FIFO and, on `start`, issues instructions one at a time.
- Holds each instruction stable for a fixed settle time, gates its write-enable bit (bit 0) to the final hold cycle, then captures `Sailida`.
- Returns each result over a valid/ready handshake and pulses `done` when the program drains.

---
 rtl/isa_secuenciador.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/isa_secuenciador.sv
// Instruction sequencer for the ISA datapath: buffers a program in a FIFO, issues each
// word for HOLD cycles with its write-enable gated to the last one, and returns results.
module isa_secuenciador #(
    parameter int DEPTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       prog_valid,
    input  logic [19:0]                prog_instr,
    output logic                       prog_ready,
    input  logic                       start,
    input  logic                       abort,
    output logic [19:0]                instruccion,
    input  logic [31:0]                sailida,
    output logic                       res_valid,
    output logic [31:0]                res_data,
    input  logic                       res_ready,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;

    localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ISSUE  = 2'd1;
    localparam logic [1:0] S_RESULT = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          res_valid_q, res_valid_d;
    logic [31:0]   res_data_q, res_data_d;
    logic          done_q, done_d;

    logic [19:0]   fifo_mem [DEPTH];
    logic          full;
    logic          push_en;
    logic          pop_en;
    logic [CW-1:0] count_after_pop;
    logic [19:0]   head;

    assign full = (count_q == FULL_CNT);
    assign head = fifo_mem[rd_ptr_q];

    always_comb begin
        // NOTE: every signal assigned here gets a default first so no latch is inferred.
        state_d     = state_q;
        hold_d      = hold_q;
        res_valid_d = res_valid_q;
        res_data_d  = res_data_q;
        done_d      = 1'b0;
        push_en     = prog_valid && !full && !abort;
        pop_en      = 1'b0;
        count_after_pop = count_q + CW'(push_en) - CW'(1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (count_q != '0) begin
                        state_d = S_ISSUE;
                        hold_d  = '0;
                    end else begin
                        done_d  = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                if (hold_q == HOLD_LAST) begin
                    state_d     = S_RESULT;
                    res_valid_d = 1'b1;
                    res_data_d  = sailida;
                end else begin
                    hold_d = hold_q + HW'(1);
                end
            end
            S_RESULT: begin
                if (res_ready) begin
                    pop_en      = 1'b1;
                    res_valid_d = 1'b0;
                    hold_d      = '0;
                    if (count_after_pop == '0) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = S_ISSUE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        wr_ptr_d = wr_ptr_q + AW'(push_en);
        rd_ptr_d = rd_ptr_q + AW'(pop_en);
        count_d  = count_q + CW'(push_en) - CW'(pop_en);

        // Abort wins over everything, including a same-cycle push or start.
        if (abort) begin
            state_d     = S_IDLE;
            hold_d      = '0;
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            res_valid_d = 1'b0;
            done_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q     <= S_IDLE;
            hold_q      <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            done_q      <= done_d;
        end
    end

    // NOTE: FIFO storage is not reset; occupancy and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (push_en) begin
            fifo_mem[wr_ptr_q] <= prog_instr;
        end
    end

    always_comb begin
        instruccion = '0;
        if (state_q == S_ISSUE) begin
            instruccion = head;
            if (hold_q != HOLD_LAST) begin
                instruccion[0] = 1'b0;
            end
        end
    end

    assign prog_ready = !full;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign busy       = (state_q != S_IDLE);
    assign done       = done_q;
    assign count      = count_q;

endmodule
